// File: rtl/tc_bank.sv
// tc_bank: bank of on-delay timer / up-counter channels feeding the t/c accumulator read mux.
// Optional build macro TC_CNT_WRAP_EN: counters wrap instead of saturating and a tcWrap pulse output is added.
module tc_bank #(
  parameter int TC_NUMBERS  = 8,
  parameter int TC_ACC_LEN  = 8,
  parameter int TC_ADDR_LEN = 3,
  parameter int TICK_DIV    = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             tcLoad,
  input  logic [TC_ADDR_LEN-1:0]           tcAddr,
  input  logic                             tcType,
  input  logic [TC_ACC_LEN-1:0]            tcPresetIn,
  input  logic [TC_NUMBERS-1:0]            tcEnIn,
  input  logic [TC_NUMBERS-1:0]            tcResetIn,
  output logic [TC_ACC_LEN*TC_NUMBERS-1:0] tcAccumOut,
  output logic [TC_NUMBERS-1:0]            tcDone
`ifdef TC_CNT_WRAP_EN
  ,
  output logic [TC_NUMBERS-1:0]            tcWrap
`endif
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TC_ACC_LEN-1:0] ACC_MAX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    DONE    = 2'd2
  } tcState_e;

  logic [PRE_W-1:0]      preCnt_q, preCnt_d;
  logic                  tick;

  logic [TC_NUMBERS-1:0] type_q, type_d;
  logic [TC_NUMBERS-1:0] done_q, done_d;
  logic [TC_NUMBERS-1:0] enPrev_q;
  logic [TC_NUMBERS-1:0] riseVec;
  logic [TC_ACC_LEN-1:0] preset_q [TC_NUMBERS];
  logic [TC_ACC_LEN-1:0] preset_d [TC_NUMBERS];
  logic [TC_ACC_LEN-1:0] acc_q    [TC_NUMBERS];
  logic [TC_ACC_LEN-1:0] acc_d    [TC_NUMBERS];
  tcState_e              state_q  [TC_NUMBERS];
  tcState_e              state_d  [TC_NUMBERS];
`ifdef TC_CNT_WRAP_EN
  logic [TC_NUMBERS-1:0] wrap_q, wrap_d;
`endif

  // Counter update: tcResetIn dominates, then a rising edge advances the count.
  function automatic logic [TC_ACC_LEN-1:0] cntNext(input logic [TC_ACC_LEN-1:0] acc,
                                                    input logic rise, input logic clr);
    if (clr) return '0;
    if (!rise) return acc;
`ifdef TC_CNT_WRAP_EN
    return acc + TC_ACC_LEN'(1);
`else
    return (acc == ACC_MAX) ? acc : acc + TC_ACC_LEN'(1);
`endif
  endfunction

  assign tick     = (preCnt_q == PRE_W'(TICK_DIV - 1));
  assign preCnt_d = tick ? '0 : preCnt_q + PRE_W'(1);
  assign riseVec  = tcEnIn & ~enPrev_q;

  always_comb begin
    for (int i = 0; i < TC_NUMBERS; i++) begin
      type_d[i]   = type_q[i];
      preset_d[i] = preset_q[i];
      acc_d[i]    = acc_q[i];
      done_d[i]   = done_q[i];
      state_d[i]  = state_q[i];
`ifdef TC_CNT_WRAP_EN
      wrap_d[i]   = 1'b0;
`endif
      if (tcLoad && (tcAddr == TC_ADDR_LEN'(i))) begin
        type_d[i]   = tcType;
        preset_d[i] = tcPresetIn;
        acc_d[i]    = '0;
        done_d[i]   = 1'b0;
        state_d[i]  = IDLE;
      end else if (!type_q[i]) begin
        if (tcResetIn[i]) begin
          acc_d[i]   = '0;
          done_d[i]  = 1'b0;
          state_d[i] = IDLE;
        end else begin
          case (state_q[i])
            IDLE: begin
              acc_d[i]  = '0;
              done_d[i] = 1'b0;
              if (tcEnIn[i]) state_d[i] = RUNNING;
            end
            RUNNING: begin
              if (!tcEnIn[i]) begin
                acc_d[i]   = '0;
                state_d[i] = IDLE;
              end else if (tick) begin
                // A zero preset still needs one tick before the timer reports done.
                if ((preset_q[i] == '0) || ((acc_q[i] + TC_ACC_LEN'(1)) == preset_q[i])) begin
                  acc_d[i]   = preset_q[i];
                  done_d[i]  = 1'b1;
                  state_d[i] = DONE;
                end else begin
                  acc_d[i] = acc_q[i] + TC_ACC_LEN'(1);
                end
              end
            end
            DONE: begin
              if (!tcEnIn[i]) begin
                acc_d[i]   = '0;
                done_d[i]  = 1'b0;
                state_d[i] = IDLE;
              end else begin
                acc_d[i]  = preset_q[i];
                done_d[i] = 1'b1;
              end
            end
            default: begin
              acc_d[i]   = '0;
              done_d[i]  = 1'b0;
              state_d[i] = IDLE;
            end
          endcase
        end
      end else begin
        state_d[i] = IDLE;
        acc_d[i]   = cntNext(acc_q[i], riseVec[i], tcResetIn[i]);
        done_d[i]  = (acc_d[i] >= preset_q[i]);
`ifdef TC_CNT_WRAP_EN
        wrap_d[i]  = riseVec[i] && !tcResetIn[i] && (acc_q[i] == ACC_MAX);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      preCnt_q <= '0;
      type_q   <= '0;
      done_q   <= '0;
      enPrev_q <= '0;
`ifdef TC_CNT_WRAP_EN
      wrap_q   <= '0;
`endif
      for (int i = 0; i < TC_NUMBERS; i++) begin
        preset_q[i] <= '0;
        acc_q[i]    <= '0;
        state_q[i]  <= IDLE;
      end
    end else begin
      preCnt_q <= preCnt_d;
      type_q   <= type_d;
      done_q   <= done_d;
      enPrev_q <= tcEnIn;
`ifdef TC_CNT_WRAP_EN
      wrap_q   <= wrap_d;
`endif
      for (int i = 0; i < TC_NUMBERS; i++) begin
        preset_q[i] <= preset_d[i];
        acc_q[i]    <= acc_d[i];
        state_q[i]  <= state_d[i];
      end
    end
  end

  for (genvar g = 0; g < TC_NUMBERS; g++) begin : g_accOut
    assign tcAccumOut[g*TC_ACC_LEN +: TC_ACC_LEN] = acc_q[g];
  end

  assign tcDone = done_q;
`ifdef TC_CNT_WRAP_EN
  assign tcWrap = wrap_q;
`endif

endmodule

// File: tb/tb_tc_bank.sv
// tb_tc_bank: directed plus randomized stimulus for tc_bank, checked every cycle against a
// tick-counting / edge-counting reference model.
module tb_tc_bank;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int A  = 3;
  localparam int TD = 4;
  localparam int MAXV = (1 << W) - 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           tcLoad;
  logic [A-1:0]   tcAddr;
  logic           tcType;
  logic [W-1:0]   tcPresetIn;
  logic [N-1:0]   tcEnIn;
  logic [N-1:0]   tcResetIn;
  logic [W*N-1:0] tcAccumOut;
  logic [N-1:0]   tcDone;
`ifdef TC_CNT_WRAP_EN
  logic [N-1:0]   tcWrap;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [N-1:0] enV;
  logic [N-1:0] clrV;

  // Reference model: timers count elapsed ticks while enabled, counters count rising edges.
  bit mIsCnt   [N];
  int mPre     [N];
  int mCount   [N];
  bit mCntDone [N];
  bit mActive  [N];
  int mTicks   [N];
  bit mPrev    [N];
  bit mWrap    [N];
  int mTickIdx;

  tc_bank #(
    .TC_NUMBERS (N),
    .TC_ACC_LEN (W),
    .TC_ADDR_LEN(A),
    .TICK_DIV   (TD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tcLoad    (tcLoad),
    .tcAddr    (tcAddr),
    .tcType    (tcType),
    .tcPresetIn(tcPresetIn),
    .tcEnIn    (tcEnIn),
    .tcResetIn (tcResetIn),
    .tcAccumOut(tcAccumOut),
    .tcDone    (tcDone)
`ifdef TC_CNT_WRAP_EN
    ,
    .tcWrap    (tcWrap)
`endif
  );

  always #5 clk = ~clk;

  function automatic int ticksNeeded(input int p);
    return (p == 0) ? 1 : p;
  endfunction

  task automatic modelStep();
    bit tick;
    bit rise;
    if (reset) begin
      mTickIdx = 0;
      for (int i = 0; i < N; i++) begin
        mIsCnt[i] = 0; mPre[i] = 0; mCount[i] = 0; mCntDone[i] = 0;
        mActive[i] = 0; mTicks[i] = 0; mPrev[i] = 0; mWrap[i] = 0;
      end
      return;
    end
    tick = ((mTickIdx % TD) == TD - 1);
    mTickIdx++;
    for (int i = 0; i < N; i++) begin
      mWrap[i] = 0;
      rise = tcEnIn[i] && !mPrev[i];
      if (tcLoad && (int'(tcAddr) == i)) begin
        mIsCnt[i] = tcType; mPre[i] = int'(tcPresetIn);
        mCount[i] = 0; mCntDone[i] = 0; mActive[i] = 0; mTicks[i] = 0;
      end else if (!mIsCnt[i]) begin
        if (tcResetIn[i] || !tcEnIn[i]) begin
          mActive[i] = 0; mTicks[i] = 0;
        end else if (!mActive[i]) begin
          mActive[i] = 1;
        end else if (tick && mTicks[i] < ticksNeeded(mPre[i])) begin
          mTicks[i]++;
        end
      end else begin
        if (tcResetIn[i]) mCount[i] = 0;
        else if (rise) begin
          if (mCount[i] < MAXV) mCount[i]++;
`ifdef TC_CNT_WRAP_EN
          else begin mCount[i] = 0; mWrap[i] = 1; end
`endif
        end
        mCntDone[i] = (mCount[i] >= mPre[i]);
      end
      mPrev[i] = tcEnIn[i];
    end
  endtask

  task automatic checkOutput(input string tag, input logic [W*N-1:0] observed,
                             input logic [W*N-1:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic compareAll();
    logic [W*N-1:0] expAcc;
    logic [N-1:0]   expDone;
    bit             tDone;
    expAcc  = '0;
    expDone = '0;
    for (int i = 0; i < N; i++) begin
      tDone = mActive[i] && (mTicks[i] >= ticksNeeded(mPre[i]));
      if (mIsCnt[i]) begin
        expAcc[i*W +: W] = W'(mCount[i]);
        expDone[i]       = mCntDone[i];
      end else begin
        expAcc[i*W +: W] = tDone ? W'(mPre[i]) : W'(mTicks[i]);
        expDone[i]       = tDone;
      end
    end
    checkOutput("accum", tcAccumOut, expAcc);
    checkOutput("done", {{(W*N-N){1'b0}}, tcDone}, {{(W*N-N){1'b0}}, expDone});
`ifdef TC_CNT_WRAP_EN
    begin
      logic [N-1:0] expWrap;
      for (int i = 0; i < N; i++) expWrap[i] = mWrap[i];
      checkOutput("wrap", {{(W*N-N){1'b0}}, tcWrap}, {{(W*N-N){1'b0}}, expWrap});
    end
`endif
  endtask

  task automatic applyStimulus(input logic rst, input logic ld, input logic [A-1:0] addr,
                               input logic typ, input logic [W-1:0] pre,
                               input logic [N-1:0] en, input logic [N-1:0] clr);
    reset = rst; tcLoad = ld; tcAddr = addr; tcType = typ; tcPresetIn = pre;
    tcEnIn = en; tcResetIn = clr;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    compareAll();
  endtask

  task automatic step(input logic ld, input int ch, input logic typ, input int pre);
    applyStimulus(1'b0, ld, A'(ch), typ, W'(pre), enV, clrV);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 0, 1'b0, 0);
  endtask

  initial begin
    enV = '0; clrV = '0;
    for (int k = 0; k < 2; k++)
      applyStimulus(1'b1, 1'b1, A'($urandom_range(0, N-1)), 1'($urandom_range(0, 1)),
                    W'($urandom), N'($urandom), N'($urandom));
    checkOutput("rst_acc", tcAccumOut, '0);
    checkOutput("rst_done", {{(W*N-N){1'b0}}, tcDone}, '0);

    // Timer ch0, preset 3: done after three ticks, cleared when enable drops.
    step(1'b1, 0, 1'b0, 3);
    enV[0] = 1'b1;
    idle(14);
    checkOutput("t0_acc", {{(W*N-W){1'b0}}, tcAccumOut[7:0]}, 64'd3);
    checkOutput("t0_done", {{(W*N-1){1'b0}}, tcDone[0]}, 64'd1);
    enV[0] = 1'b0;
    idle(1);
    checkOutput("t0_drop", {{(W*N-W){1'b0}}, tcAccumOut[7:0]}, 64'd0);

    // Timer ch1, preset 5, enable dropped early.
    step(1'b1, 1, 1'b0, 5);
    enV[1] = 1'b1;
    idle(9);
    enV[1] = 1'b0;
    idle(2);

    // Counter ch3, preset 2: three edges then a clear.
    step(1'b1, 3, 1'b1, 2);
    for (int k = 0; k < 3; k++) begin
      enV[3] = 1'b1; idle(1);
      enV[3] = 1'b0; idle(1);
    end
    checkOutput("c3_acc", {{(W*N-W){1'b0}}, tcAccumOut[31:24]}, 64'd3);
    checkOutput("c3_done", {{(W*N-1){1'b0}}, tcDone[3]}, 64'd1);
    clrV[3] = 1'b1; idle(1); clrV[3] = 1'b0;
    checkOutput("c3_clr", {{(W*N-W){1'b0}}, tcAccumOut[31:24]}, 64'd0);

    // Counter ch2 reaches 5, then a global reset discards it.
    step(1'b1, 2, 1'b1, 9);
    for (int k = 0; k < 5; k++) begin
      enV[2] = 1'b1; idle(1);
      enV[2] = 1'b0; idle(1);
    end
    checkOutput("c2_acc", {{(W*N-W){1'b0}}, tcAccumOut[23:16]}, 64'd5);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, enV, clrV);
    checkOutput("c2_rst", tcAccumOut, '0);

    // Counter ch4, preset 255, 256 edges.
    step(1'b1, 4, 1'b1, 255);
    for (int k = 0; k < 256; k++) begin
      enV[4] = 1'b1; idle(1);
      enV[4] = 1'b0; idle(1);
    end
`ifdef TC_CNT_WRAP_EN
    checkOutput("c4_acc", {{(W*N-W){1'b0}}, tcAccumOut[39:32]}, 64'd0);
    checkOutput("c4_done", {{(W*N-1){1'b0}}, tcDone[4]}, 64'd0);
`else
    checkOutput("c4_acc", {{(W*N-W){1'b0}}, tcAccumOut[39:32]}, 64'd255);
    checkOutput("c4_done", {{(W*N-1){1'b0}}, tcDone[4]}, 64'd1);
`endif

    // Priority: load ch5 with clear and rising edge in the same cycle, ch6 keeps counting.
    step(1'b1, 5, 1'b1, 1);
    step(1'b1, 6, 1'b1, 3);
    for (int k = 0; k < 2; k++) begin
      enV[5] = 1'b1; enV[6] = 1'b1; idle(1);
      enV[5] = 1'b0; enV[6] = 1'b0; idle(1);
    end
    enV[5] = 1'b1; enV[6] = 1'b1; clrV[5] = 1'b1;
    step(1'b1, 5, 1'b1, 7);
    clrV[5] = 1'b0;
    checkOutput("c5_prio", {{(W*N-W){1'b0}}, tcAccumOut[47:40]}, 64'd0);
    checkOutput("c6_acc", {{(W*N-W){1'b0}}, tcAccumOut[55:48]}, 64'd3);
    idle(3);

    // Randomized phase.
    for (int c = 0; c < 3000; c++) begin
      logic         rst;
      logic         ld;
      logic [W-1:0] pre;
      rst = ($urandom_range(0, 299) == 0);
      ld  = ($urandom_range(0, 15) == 0);
      pre = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) enV[i] = ~enV[i];
        clrV[i] = ($urandom_range(0, 40) == 0);
      end
      applyStimulus(rst, ld, A'($urandom_range(0, N-1)), 1'($urandom_range(0, 1)),
                    pre, enV, clrV);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
